// File: rtl/matrix_scan_ctrl.sv
// rtl/matrix_scan_ctrl.sv - 8x8 LED matrix column-scan sequencer with blanking and 4-bit PWM (option: ROW_ACTIVE_LOW_EN)
module matrix_scan_ctrl #(
    parameter int BLANK_CYCLES = 4,
    parameter int PWM_STEP     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] brightness,
    input  logic [7:0] fb_data,
    output logic [2:0] fb_col,
    output logic [2:0] col_counter,
    output logic       col_en,
    output logic [7:0] row_out,
    output logic       frame_done
);

    localparam int DWELL = 16 * PWM_STEP;
    localparam int DW    = $clog2(DWELL);

`ifdef ROW_ACTIVE_LOW_EN
    localparam logic [7:0] ROW_BLANK = 8'hFF;
`else
    localparam logic [7:0] ROW_BLANK = 8'h00;
`endif

    typedef enum logic [1:0] {IDLE, BLANK, LOAD, DISPLAY} state_t;

    state_t        state;
    logic [7:0]    blank_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [3:0]    bright_q;
    logic [7:0]    row_q;
    logic [2:0]    col_q;
    logic          frame_q;
    logic [DW-1:0] on_cycles;
    logic          dwell_last;

    // On-time is a prefix of the dwell window, so the strobe only ever falls once per column
    assign on_cycles  = DW'(bright_q) * DW'(PWM_STEP);
    assign dwell_last = (dwell_cnt == DW'(DWELL - 1));
    assign col_en     = (state == DISPLAY) && (dwell_cnt < on_cycles);

`ifdef ROW_ACTIVE_LOW_EN
    assign row_out = col_en ? ~row_q : ROW_BLANK;
`else
    assign row_out = col_en ? row_q : ROW_BLANK;
`endif

    assign fb_col      = col_q;
    assign col_counter = col_q;
    assign frame_done  = frame_q;

    // Scan sequencer: blank, load the column pattern, then PWM dwell; column advances only while dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            blank_cnt <= 8'd0;
            dwell_cnt <= '0;
            bright_q  <= 4'd0;
            row_q     <= 8'h00;
            col_q     <= 3'd0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                col_q     <= 3'd0;
                blank_cnt <= 8'd0;
                dwell_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= BLANK;
                        blank_cnt <= 8'd0;
                        col_q     <= 3'd0;
                    end
                    BLANK: begin
                        if (blank_cnt == 8'(BLANK_CYCLES - 1)) begin
                            state     <= LOAD;
                            blank_cnt <= 8'd0;
                        end else begin
                            blank_cnt <= blank_cnt + 8'd1;
                        end
                    end
                    LOAD: begin
                        row_q     <= fb_data;
                        bright_q  <= brightness;
                        dwell_cnt <= '0;
                        state     <= DISPLAY;
                    end
                    DISPLAY: begin
                        if (dwell_last) begin
                            dwell_cnt <= '0;
                            blank_cnt <= 8'd0;
                            col_q     <= col_q + 3'd1;
                            state     <= BLANK;
                            if (col_q == 3'd7) begin
                                frame_q <= 1'b1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb/tb_matrix_scan_ctrl.sv - scoreboard bench for matrix_scan_ctrl (BLANK_CYCLES=2, PWM_STEP=2)
module tb_matrix_scan_ctrl;

`ifdef ROW_ACTIVE_LOW_EN
    localparam logic [7:0] BLANK = 8'hFF;
`else
    localparam logic [7:0] BLANK = 8'h00;
`endif
    localparam int PERIOD = 35;
    localparam int FRAME  = 8 * PERIOD;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] brightness;
    logic [7:0] fb_data;
    logic [2:0] fb_col;
    logic [2:0] col_counter;
    logic       col_en;
    logic [7:0] row_out;
    logic       frame_done;

    matrix_scan_ctrl #(.BLANK_CYCLES(2), .PWM_STEP(2)) dut (
        .clk(clk), .rst(rst), .en(en), .brightness(brightness),
        .fb_data(fb_data), .fb_col(fb_col), .col_counter(col_counter),
        .col_en(col_en), .row_out(row_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] fb_mem [8];
    always @(posedge clk) fb_data <= fb_mem[fb_col];

    typedef struct {
        logic [2:0] col;
        logic [7:0] row;
        int         on;
        int         period;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] row_exp(input int k, input int b);
        logic [7:0] p;
        p = 8'h01 << k;
        if (b == 0) return BLANK;
`ifdef ROW_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    // monitor state
    bit         mon_en = 0;
    int         cyc, on_cnt, abs_cyc, last_frame, frames;
    bit         have_frame, off_ok, prev_en;
    logic [7:0] row_seen;
    logic [2:0] prev_col, nxt;
    exp_t       e;

    always @(negedge clk) begin
        if (!mon_en) begin
            cyc = 0; on_cnt = 0; row_seen = BLANK; off_ok = 1;
            prev_col = col_counter; prev_en = col_en;
            have_frame = 0; abs_cyc = 0;
        end else begin
            abs_cyc++;
            if (col_counter != prev_col) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    nxt = prev_col + 3'd1;
                    check_eq("col_idx", prev_col, e.col);
                    check_eq("col_next", col_counter, nxt);
                    check_eq("col_row", row_seen, e.row);
                    check_eq("col_on", on_cnt, e.on);
                    check_eq("col_off_blank", off_ok, 1);
                    check_eq("col_en_at_switch", prev_en | col_en, 0);
                    if (e.period != 0) check_eq("col_period", cyc, e.period);
                end
                cyc = 0; on_cnt = 0; row_seen = BLANK; off_ok = 1;
            end
            cyc++;
            if (col_en) begin
                on_cnt++;
                row_seen = row_out;
            end else if (row_out != BLANK) begin
                off_ok = 0;
            end
            if (frame_done) begin
                frames++;
                check_eq("frame_col", col_counter, 0);
                if (have_frame) check_eq("frame_period", abs_cyc - last_frame, FRAME);
                last_frame = abs_cyc;
                have_frame = 1;
            end
            prev_col = col_counter;
            prev_en  = col_en;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic push_col(input int k, input int b, input int period);
        exp_t x;
        x.col = 3'(k % 8);
        x.row = row_exp(k % 8, b);
        x.on = b * 2;
        x.period = period;
        sb.push_back(x);
    endtask

    task automatic wait_empty(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick;
            n++;
        end
        check_eq("sb_drain", sb.size(), 0);
    endtask

    task automatic stop_scan;
        en = 0;
        mon_en = 0;
        tick;
        tick;
    endtask

    task automatic run_cols(input int b, input int ncols, input int exp_frames);
        brightness = 4'(b);
        frames = 0;
        for (int i = 0; i < ncols; i++) push_col(i, b, (i == 0) ? 0 : PERIOD);
        en = 1;
        mon_en = 1;
        wait_empty(ncols * PERIOD + 100);
        stop_scan;
        check_eq("frame_count", frames, exp_frames);
    endtask

    initial begin
        int n;
        bit stable;
        for (int k = 0; k < 8; k++) fb_mem[k] = 8'h01 << k;
        rst = 1; en = 0; brightness = 4'd0;
        repeat (3) tick;
        rst = 0;
        tick;
        check_eq("rst_col", col_counter, 0);
        check_eq("rst_col_en", col_en, 0);
        check_eq("rst_row", row_out, BLANK);
        check_eq("rst_frame", frame_done, 0);
        check_eq("rst_fb_col", fb_col, 0);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (col_counter != 0 || col_en || row_out != BLANK || frame_done) stable = 0;
        end
        check_eq("idle_hold", stable, 1);

        run_cols(15, 16, 2);
        run_cols(0, 16, 2);
        run_cols(8, 8, 1);

        // brightness change mid-display applies to the next column
        brightness = 4'd15;
        push_col(0, 15, 0);
        sb.push_back('{3'd1, row_exp(1, 4), 8, PERIOD});
        sb.push_back('{3'd2, row_exp(2, 4), 8, PERIOD});
        en = 1;
        mon_en = 1;
        n = 0;
        while (!col_en && n < 100) begin tick; n++; end
        check_eq("wait_first_on", col_en, 1);
        brightness = 4'd4;
        wait_empty(4 * PERIOD);
        stop_scan;

        // abort at column 5
        brightness = 4'd15;
        for (int i = 0; i < 5; i++) push_col(i, 15, (i == 0) ? 0 : PERIOD);
        en = 1;
        mon_en = 1;
        wait_empty(6 * PERIOD);
        n = 0;
        while (!(col_counter == 3'd5 && col_en) && n < 100) begin tick; n++; end
        check_eq("reach_col5_on", {col_counter, col_en}, {3'd5, 1'b1});
        en = 0;
        mon_en = 0;
        tick;
        check_eq("abort_col_en", col_en, 0);
        check_eq("abort_col", col_counter, 0);
        check_eq("abort_row", row_out, BLANK);
        stable = 1;
        if (frame_done) stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (frame_done || col_en || col_counter != 0) stable = 0;
        end
        check_eq("abort_quiet", stable, 1);
        en = 1;
        n = 0;
        do begin tick; n++; end while (!col_en && n < 50);
        check_eq("restart_latency", n, 4);
        check_eq("restart_col", col_counter, 0);
        check_eq("restart_row", row_out, row_exp(0, 15));

        // asynchronous reset while displaying
        rst = 1;
        #1;
        check_eq("async_rst_col_en", col_en, 0);
        check_eq("async_rst_row", row_out, BLANK);
        check_eq("async_rst_frame", frame_done, 0);
        en = 0;
        tick;
        rst = 0;
        tick;
        check_eq("post_rst_col", col_counter, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Column-scan sequencer for the 8x8 LED matrix.
- Produces the 3-bit column index consumed by the column one-hot decoder.
- Fetches each column's row pattern from the framebuffer and drives the row lines.
- Applies per-column blanking (anti-ghosting) and 4-bit PWM brightness via a column-enable strobe.

Parameters:
- BLANK_CYCLES, 4, dark cycles before each column's load; legal range 1..255.
- PWM_STEP, 16, cycles per brightness step; column dwell = 16*PWM_STEP cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  scan enable; low forces IDLE.
- brightness  input  4  duty level; 0 = dark, 15 = 15/16 duty.
- fb_data  input  8  row pattern for column fb_col; valid one cycle after fb_col is stable (synchronous-read RAM).
- fb_col  output  3  framebuffer read address; always equals col_counter.
- col_counter  output  3  current column index, to the column decoder.
- col_en  output  1  high when the selected column may be driven; the decoder output is gated with it.
- row_out  output  8  row drive pattern, active-high by default.
- frame_done  output  1  one-cycle pulse per completed 8-column frame.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is asynchronous and active-high (rst).
  - All flops clear on rst assertion regardless of clk.
- Reset values:
  - state = IDLE; col_counter = 0; fb_col = 0; col_en = 0; frame_done = 0.
  - row_out = 8'h00 (8'hFF with the optional feature).
  - Internal blank, dwell and latched-brightness registers = 0.
- States: IDLE, BLANK, LOAD, DISPLAY.
- IDLE:
  - col_en = 0; row_out = blank value; col_counter = 0.
  - en = 1 -> BLANK, blank_cnt = 0.
- BLANK:
  - col_en = 0; row_out = blank value.
  - blank_cnt increments each cycle.
  - When blank_cnt == BLANK_CYCLES-1 -> LOAD.
- LOAD (exactly 1 cycle):
  - Latch fb_data into the row register.
  - Latch brightness into bright_q.
  - Clear dwell_cnt; go to DISPLAY.
  - col_en stays 0.
- DISPLAY:
  - Lasts 16*PWM_STEP cycles; dwell_cnt counts 0..16*PWM_STEP-1.
  - col_en = 1 iff dwell_cnt < bright_q*PWM_STEP. This is combinational from registered state, so there are no glitches on the registered outputs.
  - row_out = latched pattern when col_en = 1, otherwise the blank value.
- End of DISPLAY (last dwell cycle):
  - col_counter increments mod 8 (7 wraps to 0); go to BLANK.
  - If col_counter was 7, frame_done = 1 on the following cycle only, coincident with the first BLANK cycle of column 0.
- Column period and frame length:
  - Column period = BLANK_CYCLES + 1 + 16*PWM_STEP cycles.
  - Frame = 8 column periods.
- Brightness:
  - Sampled only in LOAD; changes mid-column take effect at the next column.
  - brightness = 0 gives col_en never asserted, but scanning and frame_done continue.
- en deassertion:
  - en = 0 in any state -> IDLE on the next edge.
  - col_counter returns to 0; col_en drops to 0; no frame_done is emitted for the aborted frame.
- Reset mid-DISPLAY: outputs take reset values immediately (asynchronous).
- Guarantee: col_counter never changes while col_en = 1.

Optional Feature:
- Macro: ROW_ACTIVE_LOW_EN.
- Defined:
  - row_out is the bitwise inverse of the latched pattern during col_en = 1.
  - Blank value is 8'hFF, including at reset.
  - This suits a PMOS high-side row driver.
- Undefined: row_out is active-high and the blank value is 8'h00.
- col_en, col_counter and frame_done are unaffected either way.

Test Plan:
- Reset with en = 0 -> col_counter = 0, col_en = 0, row_out = 8'h00, frame_done = 0; hold 20 cycles with no change.
- BLANK_CYCLES = 2, PWM_STEP = 2, brightness = 15, framebuffer col k = 8'h01<<k, en = 1:
  - Column period is 35 cycles.
  - col_en is high 30 cycles per column.
  - row_out = 8'h01..8'h80 in order.
  - frame_done pulses every 280 cycles.
- Same setup, brightness = 0 -> col_en never high, row_out stays 8'h00, frame_done still every 280 cycles; brightness = 8 -> col_en high 16 of 32 dwell cycles.
- Change brightness 15 -> 4 mid-DISPLAY -> current column keeps 30-cycle on-time; next column has 8.
- Drop en during DISPLAY of column 5 -> next cycle IDLE, col_en = 0, col_counter = 0, no frame_done; re-raise en -> scan restarts at column 0 after 2 blank cycles.
- ROW_ACTIVE_LOW_EN defined, framebuffer col 0 = 8'hA5 -> row_out = 8'h5A while col_en = 1 and 8'hFF otherwise, including after rst.
